// File: rtl/fifo_flagged.sv
// Circular-buffer FIFO with occupancy count, threshold flags and sticky error flags.
// Define FIFO_FLAGGED_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module fifo_flagged #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 2**ADDR_WIDTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  wr_ok;
    logic                  rd_ok;

    // Flags decode the count register only, never same-cycle requests.
    assign empty        = (count_q == '0);
    assign full         = (count_q == DEPTH_C);
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign count        = count_q;

    // A write into a full FIFO is only accepted when a read frees a slot in the same cycle.
    assign rd_ok = rd & ~empty;
    assign wr_ok = wr & (~full | rd_ok);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[w_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_ok) begin
                w_ptr <= w_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                r_ptr <= r_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr & ~wr_ok) begin
                overflow <= 1'b1;
            end
            if (rd & ~rd_ok) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_FLAGGED_FWFT_EN
    // Head word is always presented; rd only acknowledges it.
    assign r_data  = empty ? '0 : mem[r_ptr];
    assign r_valid = ~empty;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= rd_ok;
            if (rd_ok) begin
                r_data <= mem[r_ptr];
            end
        end
    end
`endif

endmodule
